frame_scheduler: RTL
====================

# frame_scheduler

Per-frame sequencer on the far side of the FPS divider. Watches the divider's down-count, detects each frame tick (count reaching zero), and drives the game's three render phases (erase, update, draw) in order through a four-phase req/ack handshake. Keeps a completed-frame count and a dropped-tick count, and optionally a measured frames-per-second value.

## Interface
Parameters:
- `COUNT_W`, default 25: width of the divider count input.
- `ONE_SEC`, default 50000000: measurement window in clock cycles. Used only when `FRAME_SCHED_FPS_EN` is defined.

Ports:
- `clock`  in  1  system clock; everything is on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `send_counter`  in  COUNT_W  down-count from the FPS divider; the value 0 marks a frame tick.
- `enable`  in  1  when 1, ticks in IDLE start frames; when 0, ticks in IDLE are ignored.
- `phase`  out  2  current phase: 0 = IDLE, 1 = ERASE, 2 = UPDATE, 3 = DRAW.
- `req`  out  1  request for the phase shown on `phase`. Registered.
- `ack`  in  1  acknowledge from the render engine.
- `frame_busy`  out  1  1 whenever `phase` != 0.
- `frame_count`  out  16  completed frames; wraps from 65535 to 0.
- `drop_count`  out  8  ticks lost while busy; saturates at 255.
- `fps`  out  8  frames completed in the last window. Present only with `FRAME_SCHED_FPS_EN`.

## Operation
Tick detection:
- `zero_q` is a register holding the previous cycle's value of (`send_counter` == 0).
- tick = (`send_counter` == 0) && !`zero_q`.
- A count that stays at 0 for several cycles therefore gives exactly one tick.

State machine: IDLE → ERASE → UPDATE → DRAW → IDLE.
- IDLE, on a tick with `enable`=1: go to ERASE and set `req`=1 on the same edge.
- In any phase, while `req`=1 and `ack`=1: clear `req`; the state is unchanged.
- In any phase, while `req`=0 and `ack`=0: the phase is finished.
  - ERASE or UPDATE: advance to the next phase and set `req`=1.
  - DRAW: return to IDLE and increment `frame_count`.
- While `req`=0 and `ack`=1: wait.
- Every handshake is full four-phase. The engine must drop `ack` before the next phase starts.

Ticks while busy:
- A tick in a non-IDLE state increments `drop_count` (saturating) and is not queued.
- A tick in IDLE with `enable`=0 is discarded and is not a drop.
- A tick on the same edge that DRAW returns to IDLE counts as a drop (the state was not IDLE when it was sampled).

`enable`:
- Is sampled only in IDLE.
- Deasserting it mid-frame does not abort the frame.

Reset:
- Asserting `resetn`=0 clears all outputs and state at once, including mid-handshake.
- Reset values: `phase`=0, `req`=0, `frame_busy`=0, `frame_count`=0, `drop_count`=0, `fps`=0, `zero_q`=0.

## Timing
- Tick to request: `send_counter`==0 is sampled at edge N; `phase`=1 and `req`=1 are visible after edge N, i.e. one cycle of latency.
- `ack` to `req` falling: `ack` high sampled at edge M; `req`=0 after edge M.
- `ack` low to the next phase: `ack` low sampled at edge K (with `req`=0); the next phase and `req`=1 are visible after edge K.
- Minimum frame: with `ack` returned the cycle after each `req` and dropped the cycle after `req` falls, a frame takes 9 cycles from the tick edge back to IDLE.
- `frame_count` updates on the same edge that `phase` returns to 0.
- `frame_busy` is decoded from the state register, so it has no extra cycle of delay.

## Configuration
`FRAME_SCHED_FPS_EN`, defined:
- A window counter of width ceil(log2(ONE_SEC)) runs from 0 to ONE_SEC−1 and wraps.
- A frame accumulator counts completed frames within the window, saturating at 255.
- On the wrap cycle, `fps` is loaded with the accumulator value, including any frame that completes in that same cycle.
- On that same wrap cycle the accumulator restarts at 0.

`FRAME_SCHED_FPS_EN`, undefined:
- The `fps` port, window counter and accumulator do not exist.
- All other behaviour is identical.

## Test plan
- Reset check: hold `resetn`=0 and drive `send_counter`=0 → all outputs 0. Release, then present `send_counter`=5,4,…,0 with `enable`=1 → `phase`=1 and `req`=1 one cycle after the 0 is sampled.
- Full frame: engine acks each `req` after 1 cycle and drops `ack` 1 cycle later → `phase` steps 1,2,3,0; `frame_count`=1; `drop_count`=0; 9 cycles from tick to IDLE.
- Stuck zero: hold `send_counter`=0 for 4 cycles, then 7, then 0 again → exactly two ticks.
- Overrun: stall `ack` in UPDATE while 300 ticks arrive → `drop_count`=255; after release, `frame_count` rises by 1 only.
- Mid-frame controls: deassert `enable` during DRAW → the frame completes and later ticks are ignored with `drop_count` unchanged. Assert `resetn`=0 during ERASE with `req`=1 → `req`=0 immediately, without waiting for a clock edge.
- Macro build with `ONE_SEC`=100 and a tick every 10 cycles with instant ack → `fps`=10 after the second window. Non-macro build elaborates without an `fps` port.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: turns divider ticks into erase/update/draw req/ack phases; FRAME_SCHED_FPS_EN adds an fps measurement
module frame_scheduler #(
  parameter int COUNT_W = 25,
  parameter int ONE_SEC = 50000000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [COUNT_W-1:0] send_counter,
  input  logic               enable,
  output logic [1:0]         phase,
  output logic               req,
  input  logic               ack,
  output logic               frame_busy,
  output logic [15:0]        frame_count,
  output logic [7:0]         drop_count
`ifdef FRAME_SCHED_FPS_EN
  ,
  output logic [7:0]         fps
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd3;
  logic [1:0]  r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic        r_zero_q;
  logic [15:0] r_frame_count;
  logic [7:0]  r_drop_count;
  logic        w_zero, w_tick, w_done;
  assign w_zero = send_counter == '0;
  assign w_tick = w_zero && !r_zero_q;
  // Remember last cycle's zero so a count held at zero ticks only once
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_zero_q <= 1'b0;
    else r_zero_q <= w_zero;
  // State register: current phase and the registered request
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
    end
  // Next state: enabled tick starts a frame; req/ack low-low ends a phase and DRAW+1 wraps to IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    if (r_state == S_IDLE) begin
      w_state_nxt = (w_tick && enable) ? 2'd1 : S_IDLE;
      w_req_nxt   = w_tick && enable;
    end else if (r_req && ack) begin
      w_req_nxt = 1'b0;
    end else if (!r_req && !ack) begin
      w_state_nxt = r_state + 2'd1;
      w_req_nxt   = r_state != S_DRAW;
    end
  end
  // Outputs decoded straight from the state register
  always_comb begin
    phase       = r_state;
    req         = r_req;
    frame_busy  = r_state != S_IDLE;
    frame_count = r_frame_count;
    drop_count  = r_drop_count;
    w_done      = (r_state == S_DRAW) && !r_req && !ack;
  end
  // Completed frames wrap; ticks arriving while busy saturate the drop count
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_done) r_frame_count <= r_frame_count + 16'd1;
      if (w_tick && r_state != S_IDLE && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
`ifdef FRAME_SCHED_FPS_EN
  localparam int WIN_W = (ONE_SEC > 1) ? $clog2(ONE_SEC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ONE_SEC - 1);
  logic [WIN_W-1:0] r_win;
  logic [7:0]       r_acc, r_fps, w_acc_inc;
  assign w_acc_inc = (w_done && r_acc != 8'hFF) ? r_acc + 8'd1 : r_acc;
  assign fps       = r_fps;
  // Window counter; on wrap publish the window's count (including a frame ending now) and restart
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_win <= '0;
      r_acc <= '0;
      r_fps <= '0;
    end else if (r_win == WIN_LAST) begin
      r_win <= '0;
      r_acc <= '0;
      r_fps <= w_acc_inc;
    end else begin
      r_win <= r_win + WIN_W'(1);
      r_acc <= w_acc_inc;
    end
`endif
endmodule
